// File: rtl/spi_pkg.sv
// Shared state encoding, default sizing and a small sizing helper for the SPI
// master sequencer and its clock generator.
package spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT_TX,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_READ,
      ST_CAPTURE
   } spi_state_e;

   localparam int DEF_CLK_DIV  = 4;
   localparam int DEF_BITS     = 8;
   localparam int DEF_SS_SETUP = 2;
   localparam int DEF_SS_HOLD  = 2;
   localparam int DEF_RX_TMO   = 4;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Mode-0 SPI clock divider: S_CLK idles low and toggles every CLK_DIV cycles
// while enabled. The ticks flag the cycle *before* S_CLK changes.
module spi_clk_gen #(
   parameter int CLK_DIV = 4
)(
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic s_clk,
   output logic rise_tick,
   output logic fall_tick
);

   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_cnt;
   logic          half_done;

   assign half_done = en && (div_cnt == DIV_LAST);
   assign rise_tick = half_done && !s_clk;
   assign fall_tick = half_done && s_clk;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         s_clk   <= 1'b0;
      end else if (!en) begin
         div_cnt <= '0;
         s_clk   <= 1'b0;
      end else if (half_done) begin
         div_cnt <= '0;
         s_clk   <= ~s_clk;
      end else begin
         div_cnt <= div_cnt + DW'(1);
      end
   end

endmodule

// File: rtl/spi_master_sequencer.sv
// Byte-level SPI transaction sequencer driving the sender/receiver handshake
// pins of SPI_Interface: load, select, shift BITS bits, deselect, read back.
module spi_master_sequencer
   import spi_pkg::*;
#(
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int BITS     = DEF_BITS,
   parameter int SS_SETUP = DEF_SS_SETUP,
   parameter int SS_HOLD  = DEF_SS_HOLD,
   parameter int RX_TMO   = DEF_RX_TMO
)(
   input  logic            CLK,
   input  logic            CLR,
   input  logic            START,
   input  logic [BITS-1:0] TX_BYTE,
   output logic            BUSY,
   output logic            DONE,
   output logic            ERR,
   output logic [BITS-1:0] RX_BYTE,
   output logic [BITS-1:0] TX_DATA,
   output logic            TX_WRITE,
   output logic            TE,
   input  logic            TX_FULL,
   input  logic            TX_EMPTY,
   output logic            RE,
   output logic            RX_READ,
   input  logic            RX_FULL,
   input  logic [BITS-1:0] RX_DATA,
   output logic            S_CLK,
   output logic            SS,
   output spi_state_e      DBG_STATE
);

   localparam int BW = $clog2(BITS + 1);
   localparam int CW = $clog2(max3(SS_SETUP, SS_HOLD, RX_TMO) + 1);
   localparam logic [BW-1:0] BIT_LAST   = BW'(BITS);
   localparam logic [CW-1:0] SETUP_LAST = CW'(SS_SETUP - 1);
   localparam logic [CW-1:0] HOLD_LAST  = CW'(SS_HOLD - 1);
   localparam logic [CW-1:0] TMO_LAST   = CW'(RX_TMO - 1);

   spi_state_e    state;
   logic [BW-1:0] bit_cnt;
   logic [CW-1:0] cnt;
   logic          rise_tick;
   logic          fall_tick;

   assign DBG_STATE = state;

   spi_clk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_gen (
      .clk       (CLK),
      .rst       (CLR),
      .en        (state == ST_SHIFT),
      .s_clk     (S_CLK),
      .rise_tick (rise_tick),
      .fall_tick (fall_tick)
   );

   // Strobes and DONE are registered one-cycle pulses: cleared every cycle
   // unless the current state sets them for the next one.
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state    <= ST_IDLE;
         bit_cnt  <= '0;
         cnt      <= '0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         ERR      <= 1'b0;
         RX_BYTE  <= '0;
         TX_DATA  <= '0;
         TX_WRITE <= 1'b0;
         TE       <= 1'b0;
         RE       <= 1'b0;
         RX_READ  <= 1'b0;
         SS       <= 1'b1;
      end else begin
         TX_WRITE <= 1'b0;
         TE       <= 1'b0;
         RE       <= 1'b0;
         RX_READ  <= 1'b0;
         DONE     <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (START && TX_EMPTY) begin
                  TX_DATA  <= TX_BYTE;
                  TX_WRITE <= 1'b1;
                  BUSY     <= 1'b1;
                  ERR      <= 1'b0;
                  state    <= ST_LOAD;
               end
            end
            ST_LOAD: state <= ST_WAIT_TX;
            ST_WAIT_TX: begin
               if (TX_FULL) begin
                  SS    <= 1'b0;
                  cnt   <= '0;
                  state <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (cnt == SETUP_LAST) begin
                  cnt     <= '0;
                  bit_cnt <= '0;
                  state   <= ST_SHIFT;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_SHIFT: begin
               // TE/RE land in the same cycle S_CLK goes high.
               if (rise_tick) begin
                  TE      <= 1'b1;
                  RE      <= 1'b1;
                  bit_cnt <= bit_cnt + BW'(1);
               end
               if (fall_tick && bit_cnt == BIT_LAST) begin
                  cnt   <= '0;
                  state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (cnt == HOLD_LAST) begin
                  SS    <= 1'b1;
                  cnt   <= '0;
                  state <= ST_READ;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_READ: begin
               if (RX_FULL) begin
                  RX_READ <= 1'b1;
                  RX_BYTE <= RX_DATA;
                  DONE    <= 1'b1;
                  state   <= ST_CAPTURE;
               end else if (cnt == TMO_LAST) begin
                  ERR   <= 1'b1;
                  DONE  <= 1'b1;
                  state <= ST_CAPTURE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_CAPTURE: begin
               BUSY  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_sequencer.sv
// Directed bench for spi_master_sequencer with a small sender-side model
// standing in for SPI_Interface's FULL/EMPTY flags.
module tb_spi_master_sequencer;
   import spi_pkg::*;

   logic       CLK = 1'b0;
   logic       CLR = 1'b1;
   logic       START = 1'b0;
   logic [7:0] TX_BYTE = 8'h00;
   logic       BUSY, DONE, ERR, TX_WRITE, TE, RE, RX_READ, S_CLK, SS;
   logic [7:0] RX_BYTE, TX_DATA;
   spi_state_e DBG_STATE;

   logic       tx_full;
   logic       tx_empty;
   bit         tx_block = 1'b0;
   int         tx_delay = 1;
   int         pend;
   int         te_seen;
   logic       rx_full = 1'b1;
   logic [7:0] rx_data = 8'h3C;

   int checks = 0;
   int errors = 0;

   assign tx_empty = !tx_full && !tx_block;

   always #5 CLK = ~CLK;

   spi_master_sequencer dut (
      .CLK       (CLK),
      .CLR       (CLR),
      .START     (START),
      .TX_BYTE   (TX_BYTE),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .ERR       (ERR),
      .RX_BYTE   (RX_BYTE),
      .TX_DATA   (TX_DATA),
      .TX_WRITE  (TX_WRITE),
      .TE        (TE),
      .TX_FULL   (tx_full),
      .TX_EMPTY  (tx_empty),
      .RE        (RE),
      .RX_READ   (RX_READ),
      .RX_FULL   (rx_full),
      .RX_DATA   (rx_data),
      .S_CLK     (S_CLK),
      .SS        (SS),
      .DBG_STATE (DBG_STATE)
   );

   // Sender model: FULL rises tx_delay cycles after WRITE, empties after 8 shifts.
   always @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         tx_full <= 1'b0;
         pend    <= 0;
         te_seen <= 0;
      end else begin
         if (TX_WRITE) begin
            te_seen <= 0;
            if (tx_delay <= 1) tx_full <= 1'b1;
            else pend <= tx_delay - 1;
         end else if (pend > 0) begin
            pend <= pend - 1;
            if (pend == 1) tx_full <= 1'b1;
         end
         if (TE) begin
            te_seen <= te_seen + 1;
            if (te_seen == 7) begin
               tx_full <= 1'b0;
               te_seen <= 0;
            end
         end
      end
   end

   task automatic run_txn(input logic [7:0] b, output int done_k, output int te_n,
                          output int te_bad, output int ss_low_k, output int wr_n, output int rd_n);
      logic prev;
      prev = 1'b0;
      done_k = 0; te_n = 0; te_bad = 0; ss_low_k = 0; wr_n = 0; rd_n = 0;
      TX_BYTE = b;
      START = 1'b1;
      for (int k = 1; k <= 300; k++) begin
         @(negedge CLK);
         if (k == 1) START = 1'b0;
         if (TX_WRITE) wr_n++;
         if (RX_READ) rd_n++;
         if (TE) te_n++;
         if (TE !== (S_CLK && !prev)) te_bad++;
         if (RE !== TE) te_bad++;
         if (!SS && ss_low_k == 0) ss_low_k = k;
         prev = S_CLK;
         if (DONE) begin
            done_k = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge CLK);
      checks++;
      if ({DONE, ERR, TX_WRITE, TE, RE, RX_READ, BUSY, S_CLK, SS} !== 9'b000000001) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 000000001",
                  {DONE, ERR, TX_WRITE, TE, RE, RX_READ, BUSY, S_CLK, SS});
      end
      checks++;
      if ({TX_DATA, RX_BYTE} !== 16'h0000) begin
         errors++;
         $display("FAIL reset_data: got %h expected 0000", {TX_DATA, RX_BYTE});
      end
      checks++;
      if (DBG_STATE !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_state: got %0d expected %0d", DBG_STATE, ST_IDLE);
      end
      CLR = 1'b0;
      repeat (2) @(negedge CLK);
   endtask

   task automatic test_basic();
      int done_k, te_n, te_bad, ss_k, wr_n, rd_n;
      rx_data = 8'h3C;
      run_txn(8'hA5, done_k, te_n, te_bad, ss_k, wr_n, rd_n);
      checks++;
      if (done_k !== 72) begin errors++; $display("FAIL basic_latency: got %0d expected 72", done_k); end
      checks++;
      if (te_n !== 8) begin errors++; $display("FAIL basic_te_count: got %0d expected 8", te_n); end
      checks++;
      if (te_bad !== 0) begin errors++; $display("FAIL basic_te_align: got %0d expected 0", te_bad); end
      checks++;
      if (ss_k !== 3) begin errors++; $display("FAIL basic_ss_low: got %0d expected 3", ss_k); end
      checks++;
      if ({wr_n, rd_n} !== {32'd1, 32'd1}) begin
         errors++; $display("FAIL basic_pulses: got wr %0d rd %0d expected 1 1", wr_n, rd_n);
      end
      checks++;
      if ({RX_BYTE, TX_DATA, ERR, SS} !== {8'h3C, 8'hA5, 1'b0, 1'b1}) begin
         errors++; $display("FAIL basic_data: got rx %h tx %h err %b ss %b expected 3c a5 0 1",
                             RX_BYTE, TX_DATA, ERR, SS);
      end
      @(negedge CLK);
      checks++;
      if ({BUSY, DONE} !== 2'b00) begin errors++; $display("FAIL basic_busy_drop: got %b expected 00", {BUSY, DONE}); end
   endtask

   task automatic test_tx_not_empty();
      int busy_n, wr_n;
      busy_n = 0; wr_n = 0;
      tx_block = 1'b1;
      TX_BYTE = 8'h77;
      START = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge CLK);
         if (BUSY) busy_n++;
         if (TX_WRITE) wr_n++;
      end
      START = 1'b0;
      tx_block = 1'b0;
      checks++;
      if ({busy_n, wr_n} !== {32'd0, 32'd0}) begin
         errors++; $display("FAIL not_empty_ignored: got busy %0d wr %0d expected 0 0", busy_n, wr_n);
      end
      @(negedge CLK);
   endtask

   task automatic test_tx_full_delay();
      int done_k, te_n, te_bad, ss_k, wr_n, rd_n;
      tx_delay = 5;
      run_txn(8'h5A, done_k, te_n, te_bad, ss_k, wr_n, rd_n);
      tx_delay = 1;
      checks++;
      if (ss_k !== 7) begin errors++; $display("FAIL delay_ss_low: got %0d expected 7", ss_k); end
      checks++;
      if (done_k !== 76) begin errors++; $display("FAIL delay_latency: got %0d expected 76", done_k); end
      checks++;
      if (te_n !== 8) begin errors++; $display("FAIL delay_te_count: got %0d expected 8", te_n); end
      @(negedge CLK);
   endtask

   task automatic test_rx_timeout();
      int done_k, te_n, te_bad, ss_k, wr_n, rd_n;
      rx_full = 1'b0;
      rx_data = 8'hFF;
      run_txn(8'h0F, done_k, te_n, te_bad, ss_k, wr_n, rd_n);
      checks++;
      if (done_k !== 75) begin errors++; $display("FAIL tmo_latency: got %0d expected 75", done_k); end
      checks++;
      if (ERR !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b expected 1", ERR); end
      checks++;
      if (rd_n !== 0) begin errors++; $display("FAIL tmo_rx_read: got %0d expected 0", rd_n); end
      checks++;
      if (RX_BYTE !== 8'h3C) begin errors++; $display("FAIL tmo_rx_byte: got %h expected 3c", RX_BYTE); end
      rx_full = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_clr_mid_shift();
      int te_n, done_n, busy_n, done_k, te2, te_bad, ss_k, wr_n, rd_n;
      te_n = 0; done_n = 0; busy_n = 0;
      TX_BYTE = 8'h11;
      START = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         @(negedge CLK);
         if (k == 1) START = 1'b0;
         if (TE) te_n++;
         if (te_n == 3) break;
      end
      @(negedge CLK);
      checks++;
      if ({SS, S_CLK, BUSY} !== 3'b011) begin
         errors++; $display("FAIL clr_precond: got %b expected 011", {SS, S_CLK, BUSY});
      end
      #2 CLR = 1'b1;
      #1;
      checks++;
      if ({SS, S_CLK, TE, RE, BUSY} !== 5'b10000) begin
         errors++; $display("FAIL clr_async: got %b expected 10000", {SS, S_CLK, TE, RE, BUSY});
      end
      repeat (2) @(negedge CLK);
      CLR = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge CLK);
         if (DONE) done_n++;
         if (BUSY) busy_n++;
      end
      checks++;
      if ({done_n, busy_n} !== {32'd0, 32'd0}) begin
         errors++; $display("FAIL clr_no_done: got done %0d busy %0d expected 0 0", done_n, busy_n);
      end
      rx_data = 8'h96;
      run_txn(8'h22, done_k, te2, te_bad, ss_k, wr_n, rd_n);
      checks++;
      if ({done_k, te2} !== {32'd72, 32'd8}) begin
         errors++; $display("FAIL clr_recover: got done %0d te %0d expected 72 8", done_k, te2);
      end
      checks++;
      if ({RX_BYTE, ERR} !== {8'h96, 1'b0}) begin
         errors++; $display("FAIL clr_recover_data: got %h err %b expected 96 0", RX_BYTE, ERR);
      end
      @(negedge CLK);
   endtask

   task automatic test_back_to_back();
      int wr_k[2];
      int done_k[2];
      int wr_n, done_n, idle_n;
      wr_n = 0; done_n = 0; idle_n = 0;
      wr_k[0] = 0; wr_k[1] = 0; done_k[0] = 0; done_k[1] = 0;
      rx_data = 8'hC3;
      TX_BYTE = 8'h3C;
      START = 1'b1;
      for (int k = 1; k <= 160; k++) begin
         @(negedge CLK);
         if (TX_WRITE) begin
            if (wr_n < 2) wr_k[wr_n] = k;
            wr_n++;
            if (wr_n == 2) START = 1'b0;
         end
         if (DONE) begin
            if (done_n < 2) done_k[done_n] = k;
            done_n++;
         end
         if (done_n == 1 && wr_n == 1 && !BUSY) idle_n++;
      end
      START = 1'b0;
      checks++;
      if ({wr_n, done_n} !== {32'd2, 32'd2}) begin
         errors++; $display("FAIL b2b_counts: got wr %0d done %0d expected 2 2", wr_n, done_n);
      end
      checks++;
      if ({wr_k[0], done_k[0], wr_k[1], done_k[1]} !== {32'd1, 32'd72, 32'd74, 32'd145}) begin
         errors++; $display("FAIL b2b_timing: got %0d %0d %0d %0d expected 1 72 74 145",
                            wr_k[0], done_k[0], wr_k[1], done_k[1]);
      end
      checks++;
      if (idle_n !== 1) begin errors++; $display("FAIL b2b_idle_gap: got %0d expected 1", idle_n); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_tx_not_empty();
      test_tx_full_delay();
      test_rx_timeout();
      test_clr_mid_shift();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
